// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised XNOR-feedback Fibonacci LFSR with seed load,
// lock-up recovery, period-wrap pulse and a registered threshold compare.
module lfsr_gen #(
    parameter int unsigned            WIDTH = 10,
    parameter logic [WIDTH-1:0]       TAPS  = WIDTH'(10'b10_0100_0000),
    parameter logic [WIDTH-1:0]       SEED  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] thresh,
    output logic [WIDTH-1:0] out,
    output logic             hit,
    output logic             wrap,
    output logic             lock_err
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             hit_q, hit_d;
    logic             wrap_q, wrap_d;
    logic             lock_err_q, lock_err_d;

    logic             fb;
    logic [WIDTH-1:0] shift_val;

    // Feedback bit and shifted candidate for an enabled step
    always_comb begin
        fb        = ~^(out_q & TAPS);
        shift_val = {out_q[WIDTH-2:0], fb};
    end

    // Next-state selection: load beats step; all-ones is never allowed to
    // enter the register and is replaced by SEED with a lock_err pulse.
    always_comb begin
        out_d      = out_q;
        wrap_d     = 1'b0;
        lock_err_d = 1'b0;
        if (load) begin
            if (&load_val) begin
                out_d      = SEED;
                lock_err_d = 1'b1;
            end else begin
                out_d      = load_val;
            end
        end else if (en) begin
            if (&out_q) begin
                out_d      = SEED;
                lock_err_d = 1'b1;
            end else begin
                out_d      = shift_val;
                wrap_d     = (shift_val == SEED);
            end
        end
        // Compare against the next state so hit lines up with the new out
        hit_d = (out_d > thresh);
    end

    // State and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q      <= SEED;
            hit_q      <= 1'b0;
            wrap_q     <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            hit_q      <= hit_d;
            wrap_q     <= wrap_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign out      = out_q;
    assign hit      = hit_q;
    assign wrap     = wrap_q;
    assign lock_err = lock_err_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: randomized self-checking bench for lfsr_gen against a
// behavioural reference model (parity arithmetic on integers).
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0, load = 1'b0;
    logic [9:0] load_val = '0, thresh = '0;
    logic [9:0] out;
    logic       hit, wrap, lock_err;

    logic       reset4 = 1'b0, en4 = 1'b0;
    logic [3:0] out4;
    logic       hit4, wrap4, lock_err4;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // reference model state
    int unsigned m_out = 0;
    int unsigned m4    = 0;

    always #5 clk = ~clk;

    lfsr_gen dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .thresh(thresh), .out(out), .hit(hit), .wrap(wrap), .lock_err(lock_err)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0000)) dut4 (
        .clk(clk), .reset(reset4), .en(en4), .load(1'b0), .load_val(4'h0),
        .thresh(4'h7), .out(out4), .hit(hit4), .wrap(wrap4), .lock_err(lock_err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One LFSR step: new bit is 1 when an even number of tapped bits are set
    function automatic int unsigned ref_step(input int unsigned s, input int unsigned taps,
                                             input int unsigned w);
        int unsigned ones = 0;
        int unsigned fb;
        longint unsigned mask = (64'd1 << w) - 1;
        for (int unsigned i = 0; i < w; i++)
            if (((s >> i) & 1) && ((taps >> i) & 1)) ones++;
        fb = (ones % 2 == 0) ? 1 : 0;
        return int'(((longint'(s) * 2) + fb) & mask);
    endfunction

    // Drive one cycle on the 10-bit DUT and check all outputs after the edge
    task automatic cyc(input logic l, input logic [9:0] lv, input logic e,
                       input logic [9:0] th, input string tag);
        int unsigned n;
        int unsigned w_exp = 0, lk_exp = 0, h_exp;
        load = l; load_val = lv; en = e; thresh = th;
        if (l) begin
            if (lv == 10'h3FF) begin n = 0; lk_exp = 1; end
            else n = lv;
        end else if (e) begin
            if (m_out == 32'h3FF) begin n = 0; lk_exp = 1; end
            else begin
                n = ref_step(m_out, 32'h240, 10);
                w_exp = (n == 0) ? 1 : 0;
            end
        end else begin
            n = m_out;
        end
        h_exp = (n > th) ? 1 : 0;
        @(posedge clk); #1;
        m_out = n;
        chk({tag, ".out"},  32'(out),      n);
        chk({tag, ".hit"},  32'(hit),      h_exp);
        chk({tag, ".wrap"}, 32'(wrap),     w_exp);
        chk({tag, ".lock"}, 32'(lock_err), lk_exp);
    endtask

    logic [9:0]  first8 [8] = '{10'h001, 10'h003, 10'h007, 10'h00F,
                                10'h01F, 10'h03F, 10'h07F, 10'h0FE};
    bit          visited [1024];
    int unsigned repeats, wraps;

    initial begin
        // reset state
        #2;
        chk("rst.out",  32'(out),      0);
        chk("rst.hit",  32'(hit),      0);
        chk("rst.wrap", 32'(wrap),     0);
        chk("rst.lock", 32'(lock_err), 0);
        @(negedge clk); reset = 1'b1;

        // full period from reset with visited-state scoreboard
        repeats = 0; wraps = 0;
        visited[0] = 1'b1;
        for (int unsigned i = 1; i <= 1023; i++) begin
            cyc(1'b0, 10'h000, 1'b1, 10'h1FF, "period");
            if (i <= 8) chk("seq8", 32'(out), 32'(first8[i-1]));
            if (wrap) wraps++;
            if (i < 1023) begin
                if (visited[out]) repeats++;
                visited[out] = 1'b1;
            end
        end
        chk("period.end_out", 32'(out), 0);
        chk("period.wraps",   wraps, 1);
        chk("period.repeats", repeats, 0);

        // load beats step; all-ones load recovers to SEED
        cyc(1'b1, 10'h155, 1'b1, 10'h1FF, "load155");
        chk("load155.val", 32'(out), 32'h155);
        cyc(1'b1, 10'h3FF, 1'b1, 10'h1FF, "load3ff");
        cyc(1'b0, 10'h000, 1'b0, 10'h1FF, "after_lock");

        // hit drops on a thresh change while holding
        cyc(1'b1, 10'h2AA, 1'b0, 10'h1FF, "hit_hi");
        chk("hit_hi.h", 32'(hit), 1);
        cyc(1'b0, 10'h000, 1'b0, 10'h3FF, "hit_lo");
        chk("hit_lo.h", 32'(hit), 0);
        chk("hit_lo.o", 32'(out), 32'h2AA);

        // randomized mix of load / step / hold / thresh
        for (int unsigned i = 0; i < 400; i++) begin
            logic       l, e;
            logic [9:0] lv, th;
            l  = ($urandom_range(0, 7) == 0);
            e  = $urandom_range(0, 3) != 0;
            lv = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
            th = 10'($urandom);
            cyc(l, lv, e, th, "rand");
        end

        // asynchronous reset between edges
        cyc(1'b0, 10'h000, 1'b1, 10'h000, "pre_rst");
        #3 reset = 1'b0;
        #1;
        m_out = 0;
        chk("arst.out",  32'(out),      0);
        chk("arst.hit",  32'(hit),      0);
        chk("arst.wrap", 32'(wrap),     0);
        chk("arst.lock", 32'(lock_err), 0);
        @(negedge clk); @(negedge clk); reset = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            cyc(1'b0, 10'h000, 1'b1, 10'h100, "restart");
            chk("restart.seq", 32'(out), 32'(first8[i]));
        end

        // 4-bit instance: period 15
        en = 1'b0;
        @(negedge clk); reset4 = 1'b1; en4 = 1'b1;
        wraps = 0; m4 = 0;
        for (int unsigned i = 1; i <= 45; i++) begin
            int unsigned n4;
            n4 = ref_step(m4, 32'hC, 4);
            @(posedge clk); #1;
            m4 = n4;
            chk("w4.out",  32'(out4),  n4);
            chk("w4.wrap", 32'(wrap4), (i % 15 == 0) ? 1 : 0);
            chk("w4.hit",  32'(hit4),  (n4 > 7) ? 1 : 0);
            if (wrap4) wraps++;
        end
        chk("w4.wraps", wraps, 3);
        en4 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
